// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback unit.
package wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_if.sv
// Writeback bus: ALU and load result inputs, register-file write port, hazard query.
interface wb_if;
  import wb_pkg::*;

  logic                  i_alu_valid;
  logic [REG_ADDR_W-1:0] i_alu_rd;
  logic [XLEN-1:0]       i_alu_data;
  logic                  i_ld_valid;
  logic [REG_ADDR_W-1:0] i_ld_rd;
  logic [XLEN-1:0]       i_ld_data;
  logic                  o_ld_ready;
  logic                  o_wr;
  logic [REG_ADDR_W-1:0] o_rd;
  logic [XLEN-1:0]       o_write_data;
  logic [REG_ADDR_W-1:0] i_rs1;
  logic [REG_ADDR_W-1:0] i_rs2;
  logic                  o_rs1_busy;
  logic                  o_rs2_busy;
  logic                  o_empty;

  modport slave (
    input  i_alu_valid, i_alu_rd, i_alu_data,
    input  i_ld_valid, i_ld_rd, i_ld_data,
    output o_ld_ready,
    output o_wr, o_rd, o_write_data,
    input  i_rs1, i_rs2,
    output o_rs1_busy, o_rs2_busy, o_empty
  );

  modport master (
    output i_alu_valid, i_alu_rd, i_alu_data,
    output i_ld_valid, i_ld_rd, i_ld_data,
    input  o_ld_ready,
    input  o_wr, o_rd, o_write_data,
    output i_rs1, i_rs2,
    input  o_rs1_busy, o_rs2_busy, o_empty
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of load results with per-entry squash and full parallel visibility.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  wb_entry_t             push_entry_i,
  input  logic                  pop_i,
  input  logic                  squash_i,
  input  logic [REG_ADDR_W-1:0] squash_rd_i,
  output wb_entry_t             entries_o [DEPTH],
  output wb_entry_t             head_o,
  output logic [CntW-1:0]       count_o,
  output logic                  full_o
);

  wb_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;

  // Live bits are cleared on pop so only buffered entries can ever match a compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (squash_i && (mem_q[i].rd == squash_rd_i)) mem_q[i].live <= 1'b0;
      end
      if (pop_i) begin
        mem_q[rd_ptr_q].live <= 1'b0;
        rd_ptr_q             <= rd_ptr_q + PtrW'(1);
      end
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  assign entries_o = mem_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = (count_q == CntW'(DEPTH));

endmodule

// File: rtl/wb_unit.sv
// Register-file writeback: ALU results take priority, load results queue in order behind them.
// Define WB_BYPASS_EN to let a load write straight through when nothing else is pending.
module wb_unit
  import wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  wb_if.slave bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t             entries [FIFO_DEPTH];
  wb_entry_t             head;
  wb_entry_t             push_entry;
  logic [CntW-1:0]       count;
  logic                  full;
  logic                  fifo_empty;
  logic                  ld_ready;
  logic                  alu_wr;
  logic                  ld_hs;
  logic                  head_dead;
  logic                  sel_head;
  logic                  bypass;
  logic                  push;
  logic                  pop;
  logic                  wr_d, wr_q;
  logic [REG_ADDR_W-1:0] rd_d, rd_q;
  logic [XLEN-1:0]       data_d, data_q;
  logic                  rs1_hit, rs2_hit;

  assign fifo_empty = (count == '0);
  assign ld_ready   = rst_n && !full;
  assign alu_wr     = bus.i_alu_valid && (bus.i_alu_rd != '0);
  assign ld_hs      = bus.i_ld_valid && ld_ready;
  assign head_dead  = !fifo_empty && !head.live;
  assign sel_head   = !alu_wr && !fifo_empty && head.live;

`ifdef WB_BYPASS_EN
  assign bypass = !alu_wr && fifo_empty && ld_hs && (bus.i_ld_rd != '0);
`else
  assign bypass = 1'b0;
`endif

  // A dead head drains alongside an ALU write; a live one leaves only when it is written.
  assign pop  = sel_head || head_dead;
  assign push = ld_hs && (bus.i_ld_rd != '0) && !bypass;

  always_comb begin
    push_entry      = '0;
    push_entry.rd   = bus.i_ld_rd;
    push_entry.data = bus.i_ld_data;
    // A same-cycle ALU write to the same register is younger, so the load is born dead.
    push_entry.live = !(alu_wr && (bus.i_alu_rd == bus.i_ld_rd));
  end

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .squash_i     (alu_wr),
    .squash_rd_i  (bus.i_alu_rd),
    .entries_o    (entries),
    .head_o       (head),
    .count_o      (count),
    .full_o       (full)
  );

  always_comb begin
    wr_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    if (alu_wr) begin
      wr_d   = 1'b1;
      rd_d   = bus.i_alu_rd;
      data_d = bus.i_alu_data;
    end else if (sel_head) begin
      wr_d   = 1'b1;
      rd_d   = head.rd;
      data_d = head.data;
    end else if (bypass) begin
      wr_d   = 1'b1;
      rd_d   = bus.i_ld_rd;
      data_d = bus.i_ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    rs1_hit = wr_q && (rd_q == bus.i_rs1);
    rs2_hit = wr_q && (rd_q == bus.i_rs2);
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (entries[i].live && (entries[i].rd == bus.i_rs1)) rs1_hit = 1'b1;
      if (entries[i].live && (entries[i].rd == bus.i_rs2)) rs2_hit = 1'b1;
    end
  end

  assign bus.o_ld_ready   = ld_ready;
  assign bus.o_wr         = wr_q;
  assign bus.o_rd         = rd_q;
  assign bus.o_write_data = data_q;
  assign bus.o_rs1_busy   = (bus.i_rs1 != '0) && rs1_hit;
  assign bus.o_rs2_busy   = (bus.i_rs2 != '0) && rs2_hit;
  assign bus.o_empty      = fifo_empty && !wr_q;

endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: directed scenarios plus a randomized run against a queue-based model.
module tb_wb_unit;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  wb_if bus ();

  wb_unit #(
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ent_t;

  ent_t        mq[$];
  bit          m_wr;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [31:0] dut_rf  [32];
  logic [31:0] gold_rf [32];

  always @(negedge clk) if (bus.o_wr === 1'b1) dut_rf[bus.o_rd] = bus.o_write_data;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit lv, input logic [4:0] lr, input logic [31:0] ld);
    bus.i_alu_valid = av;
    bus.i_alu_rd    = ar;
    bus.i_alu_data  = ad;
    bus.i_ld_valid  = lv;
    bus.i_ld_rd     = lr;
    bus.i_ld_data   = ld;
  endtask

  // Reference model: an in-order queue of pending loads and the expected write port.
  task automatic model_step(input bit rst, input bit av, input logic [4:0] ar,
                            input logic [31:0] ad, input bit lv, input logic [4:0] lr,
                            input logic [31:0] ld);
    bit aw, hs, byp, pop, nwr;
    logic [4:0] nrd;
    logic [31:0] ndata;
    if (!rst) begin
      mq.delete();
      m_wr = 0; m_rd = '0; m_data = '0;
      return;
    end
    aw = av && (ar != 0);
    hs = lv && (mq.size() < DEPTH);
    byp = 0; pop = 0; nwr = 0; nrd = '0; ndata = '0;
    if (aw) begin
      nwr = 1; nrd = ar; ndata = ad;
    end else if (mq.size() > 0 && mq[0].live) begin
      nwr = 1; nrd = mq[0].rd; ndata = mq[0].data; pop = 1;
    end else if (BYP && mq.size() == 0 && hs && lr != 0) begin
      nwr = 1; nrd = lr; ndata = ld; byp = 1;
    end
    if (mq.size() > 0 && !mq[0].live) pop = 1;
    if (pop) void'(mq.pop_front());
    if (aw) foreach (mq[i]) if (mq[i].rd == ar) mq[i].live = 0;
    if (hs && lr != 0 && !byp) mq.push_back('{rd: lr, data: ld, live: !(aw && ar == lr)});
    m_wr = nwr;
    if (nwr) begin m_rd = nrd; m_data = ndata; end
  endtask

  function automatic bit m_busy(input logic [4:0] rs);
    if (rs == 0) return 0;
    if (m_wr && m_rd == rs) return 1;
    foreach (mq[i]) if (mq[i].live && mq[i].rd == rs) return 1;
    return 0;
  endfunction

  task automatic test_reset;
    rst_n = 0;
    drive(1, 5'd4, 32'h1234, 1, 5'd6, 32'h5678);
    bus.i_rs1 = 5'd4; bus.i_rs2 = 5'd6;
    tick; tick;
    checks++; if (bus.o_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", bus.o_wr); end
    checks++; if (bus.o_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", bus.o_rd); end
    checks++; if (bus.o_write_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", bus.o_write_data); end
    checks++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.o_empty); end
    checks++; if (bus.o_ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.o_ld_ready); end
    checks++; if (bus.o_rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.o_rs1_busy); end
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1;
    #1;
    checks++; if (bus.o_ld_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", bus.o_ld_ready); end
    tick;
  endtask

  task automatic test_alu;
    bus.i_rs1 = 5'd5;
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    tick;
    checks++; if (bus.o_wr !== 1'b1 || bus.o_rd !== 5'd5 || bus.o_write_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_write got wr=%b rd=%0d data=%h want wr=1 rd=5 data=deadbeef", bus.o_wr, bus.o_rd, bus.o_write_data);
    end
    checks++; if (bus.o_rs1_busy !== 1'b1) begin errors++; $display("FAIL alu_busy got %b want 1", bus.o_rs1_busy); end
    drive(1, 5'd0, 32'h12345678, 0, 0, 0);
    tick;
    checks++; if (bus.o_wr !== 1'b0) begin errors++; $display("FAIL alu_rd0 got wr=%b want 0", bus.o_wr); end
    checks++; if (bus.o_rs1_busy !== 1'b0) begin errors++; $display("FAIL alu_busy_drop got %b want 0", bus.o_rs1_busy); end
    drive(0, 0, 0, 0, 0, 0);
    tick;
  endtask

  task automatic test_load_latency;
    int lat;
    drive(0, 0, 0, 1, 5'd3, 32'h11);
    tick;
    drive(0, 0, 0, 0, 0, 0);
    lat = 1;
    while (bus.o_wr !== 1'b1 && lat < 10) begin tick; lat++; end
    checks++; if (lat != (BYP ? 1 : 2)) begin errors++; $display("FAIL load_latency got %0d want %0d", lat, BYP ? 1 : 2); end
    checks++; if (bus.o_rd !== 5'd3 || bus.o_write_data !== 32'h11) begin
      errors++; $display("FAIL load_write got rd=%0d data=%h want rd=3 data=11", bus.o_rd, bus.o_write_data);
    end
    tick;
    checks++; if (bus.o_wr !== 1'b0 || bus.o_empty !== 1'b1) begin
      errors++; $display("FAIL load_idle got wr=%b empty=%b want wr=0 empty=1", bus.o_wr, bus.o_empty);
    end
  endtask

  task automatic test_squash;
    int n7;
    bus.i_rs1 = 5'd7;
    drive(1, 5'd1, 32'hA, 1, 5'd7, 32'h55);
    tick;
    drive(1, 5'd7, 32'h22, 0, 0, 0);
    #1;
    checks++; if (bus.o_rs1_busy !== 1'b1) begin errors++; $display("FAIL squash_busy_pending got %b want 1", bus.o_rs1_busy); end
    tick;
    checks++; if (bus.o_wr !== 1'b1 || bus.o_rd !== 5'd7 || bus.o_write_data !== 32'h22) begin
      errors++; $display("FAIL squash_alu got wr=%b rd=%0d data=%h want wr=1 rd=7 data=22", bus.o_wr, bus.o_rd, bus.o_write_data);
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (bus.o_rs1_busy !== 1'b1) begin errors++; $display("FAIL squash_busy_wr got %b want 1", bus.o_rs1_busy); end
    n7 = 0;
    repeat (6) begin tick; if (bus.o_wr === 1'b1 && bus.o_rd == 5'd7) n7++; end
    checks++; if (n7 != 0) begin errors++; $display("FAIL squash_extra_writes got %0d want 0", n7); end
    checks++; if (bus.o_rs1_busy !== 1'b0 || bus.o_empty !== 1'b1) begin
      errors++; $display("FAIL squash_drained got busy=%b empty=%b want busy=0 empty=1", bus.o_rs1_busy, bus.o_empty);
    end
  endtask

  task automatic test_full;
    int   acc;
    logic rdy5;
    acc = 0; rdy5 = 1'bx;
    for (int c = 0; c < 5; c++) begin
      drive(1, 5'(1 + c), 32'(c), 1, 5'(10 + acc), 32'hA0 + 32'(acc));
      #1;
      if (c == 4) rdy5 = bus.o_ld_ready;
      if (bus.o_ld_ready === 1'b1) acc++;
      tick;
    end
    checks++; if (acc != 4) begin errors++; $display("FAIL full_accepted got %0d want 4", acc); end
    checks++; if (rdy5 !== 1'b0) begin errors++; $display("FAIL full_ready_5th got %b want 0", rdy5); end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (bus.o_ld_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready got %b want 0", bus.o_ld_ready); end
    for (int j = 0; j < 4; j++) begin
      tick;
      checks++; if (bus.o_wr !== 1'b1 || bus.o_rd !== 5'(10 + j) || bus.o_write_data !== 32'hA0 + 32'(j)) begin
        errors++; $display("FAIL full_drain%0d got wr=%b rd=%0d data=%h want wr=1 rd=%0d data=%h",
                           j, bus.o_wr, bus.o_rd, bus.o_write_data, 10 + j, 32'hA0 + 32'(j));
      end
      if (j == 0) begin
        checks++; if (bus.o_ld_ready !== 1'b1) begin errors++; $display("FAIL full_ready_rise got %b want 1", bus.o_ld_ready); end
      end
    end
    tick;
    checks++; if (bus.o_wr !== 1'b0 || bus.o_empty !== 1'b1) begin
      errors++; $display("FAIL full_end got wr=%b empty=%b want wr=0 empty=1", bus.o_wr, bus.o_empty);
    end
  endtask

  task automatic test_same_cycle;
    int n;
    drive(1, 5'd9, 32'h99, 1, 5'd9, 32'h77);
    tick;
    checks++; if (bus.o_wr !== 1'b1 || bus.o_rd !== 5'd9 || bus.o_write_data !== 32'h99) begin
      errors++; $display("FAIL same_alu got wr=%b rd=%0d data=%h want wr=1 rd=9 data=99", bus.o_wr, bus.o_rd, bus.o_write_data);
    end
    drive(0, 0, 0, 0, 0, 0);
    n = 0;
    repeat (5) begin tick; if (bus.o_wr === 1'b1) n++; end
    checks++; if (n != 0) begin errors++; $display("FAIL same_load_written got %0d writes want 0", n); end
    checks++; if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL same_empty got %b want 1", bus.o_empty); end
  endtask

  task automatic test_reset_mid;
    int n;
    for (int c = 0; c < 3; c++) begin
      drive(1, 5'd1, 32'(c), 1, 5'(20 + c), 32'hC0 + 32'(c));
      tick;
    end
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 0;
    tick;
    checks++; if (bus.o_wr !== 1'b0 || bus.o_empty !== 1'b1) begin
      errors++; $display("FAIL midreset got wr=%b empty=%b want wr=0 empty=1", bus.o_wr, bus.o_empty);
    end
    rst_n = 1;
    n = 0;
    repeat (6) begin tick; if (bus.o_wr === 1'b1 && bus.o_rd >= 5'd20 && bus.o_rd <= 5'd22) n++; end
    checks++; if (n != 0) begin errors++; $display("FAIL midreset_leak got %0d writes want 0", n); end
  endtask

  task automatic test_random;
    bit av, lv, hs;
    logic [4:0] ar, lr;
    logic [31:0] ad, ld;
    rst_n = 0;
    drive(0, 0, 0, 0, 0, 0);
    tick;
    model_step(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1;
    for (int r = 0; r < 32; r++) begin dut_rf[r] = '0; gold_rf[r] = '0; end
    for (int cyc = 0; cyc < 2015; cyc++) begin
      av = 0; lv = 0; ar = '0; lr = '0; ad = '0; ld = '0;
      if (cyc < 2000) begin
        av = ($urandom_range(0, 99) < 45);
        lv = ($urandom_range(0, 99) < 60);
        ar = 5'($urandom_range(0, 7));
        lr = 5'($urandom_range(0, 7));
        ad = $urandom;
        ld = $urandom;
      end
      drive(av, ar, ad, lv, lr, ld);
      bus.i_rs1 = 5'($urandom_range(0, 7));
      bus.i_rs2 = 5'($urandom_range(0, 7));
      #1;
      checks++; if (bus.o_ld_ready !== (mq.size() < DEPTH)) begin
        errors++; $display("FAIL rnd_ready cyc=%0d got %b want %b", cyc, bus.o_ld_ready, mq.size() < DEPTH);
      end
      checks++; if (bus.o_rs1_busy !== m_busy(bus.i_rs1) || bus.o_rs2_busy !== m_busy(bus.i_rs2)) begin
        errors++; $display("FAIL rnd_busy cyc=%0d got %b%b want %b%b", cyc, bus.o_rs1_busy, bus.o_rs2_busy,
                           m_busy(bus.i_rs1), m_busy(bus.i_rs2));
      end
      checks++; if (bus.o_empty !== (mq.size() == 0 && !m_wr)) begin
        errors++; $display("FAIL rnd_empty cyc=%0d got %b want %b", cyc, bus.o_empty, mq.size() == 0 && !m_wr);
      end
      // Program order: a load accepted this cycle is older than a same-cycle ALU result.
      hs = lv && (mq.size() < DEPTH);
      if (hs && lr != 0) gold_rf[lr] = ld;
      if (av && ar != 0) gold_rf[ar] = ad;
      model_step(1, av, ar, ad, lv, lr, ld);
      tick;
      checks++; if (bus.o_wr !== m_wr || (m_wr && (bus.o_rd !== m_rd || bus.o_write_data !== m_data))) begin
        errors++; $display("FAIL rnd_write cyc=%0d got wr=%b rd=%0d data=%h want wr=%b rd=%0d data=%h",
                           cyc, bus.o_wr, bus.o_rd, bus.o_write_data, m_wr, m_rd, m_data);
      end
    end
    @(negedge clk);
    for (int r = 1; r < 32; r++) begin
      checks++; if (dut_rf[r] !== gold_rf[r]) begin
        errors++; $display("FAIL rnd_regfile x%0d got %h want %h", r, dut_rf[r], gold_rf[r]);
      end
    end
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    bus.i_rs1 = '0;
    bus.i_rs2 = '0;
    @(posedge clk);
    #1;
    test_reset;
    test_alu;
    test_load_latency;
    test_squash;
    test_full;
    test_same_cycle;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
